// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen: HDMI raster timing generator pulling RGB888 pixels from a show-ahead FIFO.
// Define HDMI_TEST_PATTERN_EN to add the test_pattern input and its colour-bar override.
module hdmi_video_timing_gen #(
    parameter int          H_ACTIVE    = 1920,
    parameter int          H_FP        = 88,
    parameter int          H_SYNC      = 44,
    parameter int          H_BP        = 148,
    parameter int          V_ACTIVE    = 1080,
    parameter int          V_FP        = 4,
    parameter int          V_SYNC      = 5,
    parameter int          V_BP        = 36,
    parameter logic        HS_POL      = 1'b1,
    parameter logic        VS_POL      = 1'b1,
    parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
    input  logic        tx_clock,
    input  logic        tx_rst_n,
    input  logic        enable,
    input  logic        clear_status,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    input  logic        pixel_sof,
`ifdef HDMI_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        pixel_ready,
    output logic [23:0] vid_data,
    output logic        vid_de,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic [15:0] underflow_cnt,
    output logic        sof_err
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [1:0] IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          origin, active, sof_bad, show, starve, pattern;
    logic [23:0]   bar_color, data_nxt;

`ifdef HDMI_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [HW-1:0] bar_raw;
    always_comb begin
        bar_raw   = h_cnt / HW'(BAR_W);
        bar_color = BARS[bar_raw > HW'(7) ? 3'd7 : bar_raw[2:0]];
        pattern   = test_pattern;
    end
`else
    always_comb begin
        bar_color = BLANK_COLOR;
        pattern   = 1'b0;
    end
`endif

    always_comb begin
        origin      = h_cnt == '0 && v_cnt == '0;
        active      = state == RUN && h_cnt < H_ACT && v_cnt < V_ACT;
        pixel_ready = state == SYNC ? pixel_valid && !pixel_sof
                                    : active && pixel_valid && pixel_sof == origin;
        sof_bad     = active && pixel_valid && pixel_sof != origin;
        state_nxt   = !enable        ? IDLE
                    : state == IDLE  ? SYNC
                    : state == SYNC  ? (pixel_valid && pixel_sof ? RUN : SYNC)
                    : state == RUN   ? (origin && pixel_valid && !pixel_sof ? SYNC : RUN)
                    : IDLE;
        // Raster outputs only survive a cycle that stays in RUN; aborts and resyncs blank at once.
        show        = state == RUN && state_nxt == RUN;
        starve      = show && active && !pattern && !pixel_ready;
        data_nxt    = !(show && active) ? BLANK_COLOR
                    : pattern           ? bar_color
                    : pixel_ready       ? pixel_data
                    : BLANK_COLOR;
    end

    always_ff @(posedge tx_clock or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state         <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            vid_data      <= BLANK_COLOR;
            vid_de        <= 1'b0;
            vid_hsync     <= !HS_POL;
            vid_vsync     <= !VS_POL;
            underflow_cnt <= '0;
            sof_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            h_cnt         <= !show || h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
            v_cnt         <= !show ? '0 : h_cnt != H_LAST ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
            vid_data      <= data_nxt;
            vid_de        <= show && active;
            vid_hsync     <= show && h_cnt >= H_SS && h_cnt < H_SE ? HS_POL : !HS_POL;
            vid_vsync     <= show && v_cnt >= V_SS && v_cnt < V_SE ? VS_POL : !VS_POL;
            underflow_cnt <= clear_status ? '0
                           : starve && underflow_cnt != '1 ? underflow_cnt + 1'b1
                           : underflow_cnt;
            sof_err       <= !clear_status && (sof_err || sof_bad);
        end
    end
endmodule
